// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian bytes into 32-bit words and writes them
// to the imem, then releases the core. Optional trailing XOR checksum via IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    // state  | meaning
    // IDLE   | waiting for start, core held in reset
    // RECV   | accepting payload bytes into the word buffer
    // WRITE  | one-cycle imem write of the assembled word
    // CHECK  | accepting the trailing checksum byte (checksum build only)
    // DONE   | load finished; core released when err=0
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_AFTER_LAST = S_CHECK;
`else
    localparam logic [2:0] S_AFTER_LAST = S_DONE;
`endif

    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_EXT = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       word_buf;
    logic [ADDR_W:0]   len_sat;
    logic              last_word;

    assign len_sat   = (word_len > DEPTH) ? DEPTH : word_len;
    assign last_word = (({1'b0, word_idx} + ONE_EXT) == len);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_r;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            len      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_buf <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
            err_r    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len      <= len_sat;
                        word_idx <= '0;
                        byte_idx <= '0;
                        word_buf <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
                        err_r    <= 1'b0;
`endif
                        state    <= (len_sat == '0) ? S_AFTER_LAST : S_RECV;
                    end
                end
                S_RECV: begin
                    if (byte_valid) begin
                        case (byte_idx)
                            2'd0:    word_buf[7:0]   <= byte_data;
                            2'd1:    word_buf[15:8]  <= byte_data;
                            2'd2:    word_buf[23:16] <= byte_data;
                            default: word_buf[31:24] <= byte_data;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_data;
`endif
                        if (byte_idx == 2'd3) state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (last_word) begin
                        state <= S_AFTER_LAST;
                    end else begin
                        word_idx <= word_idx + ADDR_W'(1);
                        state    <= S_RECV;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (byte_valid) begin
                        err_r <= (byte_data != csum);
                        state <= S_DONE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready = (state == S_RECV) || (state == S_CHECK);
    assign busy       = (state == S_RECV) || (state == S_WRITE) || (state == S_CHECK);
    assign err        = err_r;
`else
    assign byte_ready = (state == S_RECV);
    assign busy       = (state == S_RECV) || (state == S_WRITE);
    assign err        = 1'b0;
`endif

    assign wr_en     = (state == S_WRITE);
    assign wr_addr   = word_idx;
    assign wr_data   = word_buf;
    assign done      = (state == S_DONE);
    assign cpu_rst_n = (state == S_DONE) && !err;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the target instruction memory (DEPTH = 2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-005 SHALL have port word_len  input  ADDR_W+1  number of 32-bit words to load, sampled when start is accepted.
REQ-006 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-007 SHALL have port byte_data  input  8  incoming program byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-010 SHALL have port wr_addr  output  ADDR_W  word address of the write.
REQ-011 SHALL have port wr_data  output  32  instruction word to write.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  load finished (level).
REQ-014 SHALL have port err  output  1  checksum mismatch (level).
REQ-015 SHALL have port cpu_rst_n  output  1  active-low hold for the core; released only after a good load.

Function
REQ-016 SHALL implement states IDLE, RECV, WRITE, CHECK, DONE.
REQ-017 A byte SHALL transfer only on a cycle with byte_valid=1 and byte_ready=1; byte_ready=1 only in RECV and CHECK.
REQ-018 IDLE or DONE with start=1 SHALL latch word_len, clear word index, byte index, checksum, err, and go to RECV; start in RECV/WRITE/CHECK is ignored.
REQ-019 word_len=0 SHALL go directly to DONE (via CHECK when checksum is enabled); word_len>DEPTH SHALL saturate to DEPTH.
REQ-020 RECV SHALL pack bytes little-endian: 1st byte -> bits 7:0, 4th byte -> bits 31:24.
REQ-021 The cycle after the 4th byte is accepted SHALL be WRITE: wr_en=1 for exactly one cycle, wr_addr=word index, wr_data=assembled word; byte_ready=0.
REQ-022 After WRITE, last word (index = len-1) -> CHECK if enabled else DONE; otherwise index+1 and back to RECV.
REQ-023 wr_en SHALL be 0 in every state except WRITE; wr_addr/wr_data are don't-care when wr_en=0.
REQ-024 busy=1 in RECV, WRITE, CHECK; done=1 only in DONE.
REQ-025 cpu_rst_n SHALL be 0 in all states except DONE with err=0; a restart from DONE drives it 0 again the next cycle.
REQ-026 Byte stalls (byte_valid=0) of any length SHALL not alter state or partial word.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, wr_en=0, byte_ready=0, busy=0, done=0, err=0, cpu_rst_n=0, clear all counters, checksum and partial word.
REQ-028 Reset mid-load SHALL abandon the load with no further write; a partial word is discarded.

Configuration
REQ-029 Macro IMEM_LOADER_CHECKSUM_EN defined: running XOR of all payload bytes kept; CHECK accepts one trailing byte; mismatch -> err=1 in DONE, cpu_rst_n stays 0; match -> err=0.
REQ-030 Macro undefined: no CHECK state or checksum register, WRITE of last word goes to DONE, err tied 0.

Verification
REQ-031 Reset then idle 10 cycles -> busy=0, done=0, wr_en=0, cpu_rst_n=0, byte_ready=0.
REQ-032 start, word_len=2, bytes 93 00 A0 00 13 01 40 01 back-to-back -> writes addr0=0x00A00093, addr1=0x01400113, one cycle each, byte_ready=0 on WRITE cycles.
REQ-033 Same load with byte_valid gapped by 3 idle cycles between bytes -> identical writes, no extra wr_en.
REQ-034 Checksum enabled, same payload, trailing 0x60 -> done=1, err=0, cpu_rst_n=1; trailing 0x61 -> done=1, err=1, cpu_rst_n=0.
REQ-035 rst_n low after 6th byte of word_len=2 load -> only addr0 write seen, IDLE after reset, new load of word_len=1 bytes 13 00 00 00 writes addr0=0x00000013.
REQ-036 word_len=300 with ADDR_W=8 -> exactly 256 writes, addr 0x00..0xFF, then DONE.
